// File: rtl/rc5_scan_ctrl.sv
// Scan-chain validation controller: serial stimulus in, core run with timeout, serial result out.
// Optional stimulus/result parity: define SCAN_PARITY_EN.
`timescale 1ns/1ps
module rc5_scan_ctrl #(
    parameter int IN_W        = 168,
    parameter int OUT_W       = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_en,
    input  logic             scan_in,
    input  logic             begin_validate,
    output logic             scan_out,
    output logic [IN_W-1:0]  core_in,
    output logic             core_start,
    input  logic             core_done,
    input  logic [OUT_W-1:0] core_out,
    output logic             busy,
    output logic             val_done,
    output logic             parity_err
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
`ifdef SCAN_PARITY_EN
    localparam int SI_W = IN_W + 1;
    localparam int SO_W = OUT_W + 2;
`else
    localparam int SI_W = IN_W;
    localparam int SO_W = OUT_W + 1;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_APPLY = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [SI_W-1:0]  in_sr_q, in_sr_d;
    logic [SO_W-1:0]  out_sr_q, out_sr_d;
    logic [IN_W-1:0]  core_in_q, core_in_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             perr_q, perr_d;
    logic [SO_W-1:0]  cap_word;

    // Done strobe wins over the timeout: the flag is simply core_done.
`ifdef SCAN_PARITY_EN
    assign cap_word = {core_out, core_done, ^core_out};
`else
    assign cap_word = {core_out, core_done};
`endif

    always_comb begin
        state_d   = state_q;
        in_sr_d   = in_sr_q;
        out_sr_d  = out_sr_q;
        core_in_d = core_in_q;
        cnt_d     = cnt_q;
        perr_d    = perr_q;
        case (state_q)
            S_IDLE: begin
                if (scan_en) begin
                    in_sr_d = {in_sr_q[SI_W-2:0], scan_in};
                end else if (begin_validate) begin
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
`ifdef SCAN_PARITY_EN
                perr_d = 1'b0;
                if (^in_sr_q) begin
                    perr_d   = 1'b1;
                    out_sr_d = {{OUT_W{1'b0}}, 2'b01};
                    state_d  = S_DONE;
                end else begin
                    core_in_d = in_sr_q[IN_W:1];
                    state_d   = S_START;
                end
`else
                core_in_d = in_sr_q;
                state_d   = S_START;
`endif
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (core_done || cnt_q == CNT_LAST) begin
                    out_sr_d = cap_word;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (scan_en) begin
                    out_sr_d = {out_sr_q[SO_W-2:0], 1'b0};
                end
                if (!begin_validate) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            in_sr_q   <= '0;
            out_sr_q  <= '0;
            core_in_q <= '0;
            cnt_q     <= '0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_sr_q   <= in_sr_d;
            out_sr_q  <= out_sr_d;
            core_in_q <= core_in_d;
            cnt_q     <= cnt_d;
            perr_q    <= perr_d;
        end
    end

    assign scan_out   = out_sr_q[SO_W-1];
    assign core_in    = core_in_q;
    assign core_start = (state_q == S_START);
    assign busy       = (state_q == S_APPLY) || (state_q == S_START) ||
                        (state_q == S_WAIT);
    assign val_done   = (state_q == S_DONE);
    assign parity_err = perr_q;

endmodule

// File: tb/tb_rc5_scan_ctrl.sv
// Scoreboard bench for rc5_scan_ctrl: serial load, run, timeout, reset and scan-out.
`timescale 1ns/1ps
module tb_rc5_scan_ctrl;
    localparam int IN_W  = 168;
    localparam int OUT_W = 32;
    localparam int TO    = 16;
`ifdef SCAN_PARITY_EN
    localparam int SO_W = OUT_W + 2;
`else
    localparam int SO_W = OUT_W + 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             scan_en = 1'b0;
    logic             scan_in = 1'b0;
    logic             begin_validate = 1'b0;
    logic             scan_out;
    logic [IN_W-1:0]  core_in;
    logic             core_start;
    logic             core_done = 1'b0;
    logic [OUT_W-1:0] core_out = '0;
    logic             busy;
    logic             val_done;
    logic             parity_err;

    int checks = 0;
    int errors = 0;
    int n_start = 0;
    logic exp_q[$];

    rc5_scan_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(scan_in),
        .begin_validate(begin_validate), .scan_out(scan_out),
        .core_in(core_in), .core_start(core_start), .core_done(core_done),
        .core_out(core_out), .busy(busy), .val_done(val_done),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (core_start) n_start++;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [IN_W-1:0] v);
        for (int i = IN_W - 1; i >= 0; i--) begin
            scan_in = v[i];
            scan_en = 1'b1;
            tick();
        end
`ifdef SCAN_PARITY_EN
        scan_in = ^v;
        tick();
`endif
        scan_en = 1'b0;
        scan_in = 1'b0;
    endtask

    task automatic push_res(input logic [OUT_W-1:0] w, input logic f);
        for (int i = OUT_W - 1; i >= 0; i--) exp_q.push_back(w[i]);
        exp_q.push_back(f);
`ifdef SCAN_PARITY_EN
        exp_q.push_back(^w);
`endif
    endtask

    task automatic unload();
        logic b;
        for (int i = 0; i < SO_W; i++) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 256'(1), 256'(0));
                b = 1'b0;
            end else begin
                b = exp_q.pop_front();
            end
            chk("scan_out", 256'(scan_out), 256'(b));
            scan_en = 1'b1;
            tick();
        end
        scan_en = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!core_start && n < 20) begin
            tick();
            n++;
        end
        if (!core_start) chk("start_timeout", 256'(0), 256'(1));
    endtask

    logic [IN_W-1:0] v1, v2;
    int n, s0;

    initial begin
        v1 = {1'b0, 1'b1, 1'b1, 5'h1F, 32'hD87FAB42,
              128'h2B7E151628AED2A6ABF7158809CF4F3C};
        v2 = {8'hA5, 32'h0123_4567, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978};
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_vdone", 256'(val_done), 256'(0));
        chk("rst_start", 256'(core_start), 256'(0));
        chk("rst_sout", 256'(scan_out), 256'(0));
        chk("rst_perr", 256'(parity_err), 256'(0));
        chk("rst_core_in", 256'(core_in), 256'(0));

        // Load and run; core answers after 10 WAIT cycles.
        load(v1);
        begin_validate = 1'b1;
        tick();
        chk("apply_busy", 256'(busy), 256'(1));
        chk("apply_nostart", 256'(core_start), 256'(0));
        tick();
        chk("core_in_v1", 256'(core_in), 256'(v1));
        chk("start_pulse", 256'(core_start), 256'(1));
        tick();
        chk("start_one_cyc", 256'(core_start), 256'(0));
        repeat (9) tick();
        chk("wait_busy", 256'(busy), 256'(1));
        core_out = 32'hA5A5_0F0F;
        core_done = 1'b1;
        push_res(32'hA5A5_0F0F, 1'b1);
        tick();
        core_done = 1'b0;
        chk("done_vdone", 256'(val_done), 256'(1));
        chk("done_busy", 256'(busy), 256'(0));
        chk("n_start_1", 256'(n_start), 256'(1));
        unload();
        begin_validate = 1'b0;
        tick();
        chk("idle_vdone", 256'(val_done), 256'(0));

        // Re-run the preserved vector with no done: timeout.
        core_out = 32'h1234_5678;
        begin_validate = 1'b1;
        wait_start();
        tick();
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        chk("timeout_cycles", 256'(n), 256'(TO));
        chk("rerun_core_in", 256'(core_in), 256'(v1));
        push_res(32'h1234_5678, 1'b0);
        s0 = n_start;
        repeat (5) tick();
        chk("hold_vdone", 256'(val_done), 256'(1));
        chk("hold_nostart", 256'(n_start), 256'(s0));
        unload();
        begin_validate = 1'b0;
        tick();

        // Request held during loading waits for scan_en to drop.
        begin_validate = 1'b1;
        load(v2);
        chk("req_wait_busy", 256'(busy), 256'(0));
        chk("req_wait_nostart", 256'(n_start), 256'(s0));
        tick();
        chk("req_apply", 256'(busy), 256'(1));
        tick();
        chk("core_in_v2", 256'(core_in), 256'(v2));
        tick();
        repeat (TO - 1) tick();
        core_out = 32'hC0DE_F00D;
        core_done = 1'b1;
        push_res(32'hC0DE_F00D, 1'b1);
        tick();
        core_done = 1'b0;
        chk("edge_vdone", 256'(val_done), 256'(1));
        unload();
        begin_validate = 1'b0;
        tick();

        // Reset in the middle of WAIT.
        begin_validate = 1'b1;
        wait_start();
        repeat (4) tick();
        s0 = n_start;
        rst = 1'b1;
        begin_validate = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_wait_core_in", 256'(core_in), 256'(0));
        chk("rst_wait_busy", 256'(busy), 256'(0));
        repeat (4) tick();
        chk("rst_wait_nostart", 256'(n_start), 256'(s0));
        begin_validate = 1'b1;
        tick();
        tick();
        chk("rst_cleared_in_sr", 256'(core_in), 256'(0));
        rst = 1'b1;
        begin_validate = 1'b0;
        tick();
        rst = 1'b0;

`ifdef SCAN_PARITY_EN
        // Corrupt parity bit: direct to DONE, no start.
        load(v2);
        tick();
        rst = 1'b0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            scan_in = v1[i];
            scan_en = 1'b1;
            tick();
        end
        scan_in = ~(^v1);
        tick();
        scan_en = 1'b0;
        s0 = n_start;
        begin_validate = 1'b1;
        tick();
        tick();
        chk("perr_flag", 256'(parity_err), 256'(1));
        chk("perr_vdone", 256'(val_done), 256'(1));
        chk("perr_core_in", 256'(core_in), 256'(0));
        chk("perr_nostart", 256'(n_start), 256'(s0));
        for (int i = 0; i < OUT_W + 1; i++) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        unload();
        begin_validate = 1'b0;
        tick();
`endif

        chk("sb_drained", 256'(exp_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
